// File: rtl/ibex_pkg.sv
// ibex_pkg: shared opcode/state types and the iteration count for the serial multiply/divide unit.
package ibex_pkg;
  typedef enum logic [1:0] {MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM} md_op_e;
  typedef enum logic [2:0] {IDLE, ABS, CALC, FIX, DONE} md_state_e;
  localparam int MD_CALC_CYCLES = 32;
endpackage

// File: rtl/ibex_multdiv_addsub.sv
// ibex_multdiv_addsub: Width+1-bit add or subtract with carry-out (carry = no borrow on subtract).
module ibex_multdiv_addsub #(
  parameter int Width = 32
) (
  input  logic [Width:0] a,
  input  logic [Width:0] b,
  input  logic           sub,
  output logic [Width:0] sum,
  output logic           cout
);
  logic [Width+1:0] t;
  assign t = {1'b0, a} + {1'b0, sub ? ~b : b} + (Width+2)'(sub);
  assign sum = t[Width:0];
  assign cout = t[Width+1];
endmodule

// File: rtl/ibex_multdiv_serial.sv
// ibex_multdiv_serial: iterative 32-cycle multiplier/divider; divider present only with IBEX_MULTDIV_DIV_EN.
module ibex_multdiv_serial
  import ibex_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  md_op_e           op_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [Width-1:0] op_a_i,
  input  logic [Width-1:0] op_b_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] result_o
);
`ifdef IBEX_MULTDIV_DIV_EN
  localparam logic DivEn = 1'b1;
`else
  localparam logic DivEn = 1'b0;
`endif
  md_state_e state, state_n;
  md_op_e op_q;
  logic [1:0] sm_q;
  logic [Width-1:0] hi, lo, mc, res, a_abs, b_abs;
  logic [4:0] cnt;
  logic neg_res, neg_rem, is_div, a_neg, b_neg, cout;
  logic [Width:0] add_a, add_b, sum;
  logic [2*Width-1:0] prod;
  // During ABS the raw operands still sit in mc (a) and lo (b).
  assign is_div = DivEn && op_q[1];
  assign a_neg = sm_q[0] & mc[Width-1];
  assign b_neg = sm_q[1] & lo[Width-1];
  assign a_abs = a_neg ? -mc : mc;
  assign b_abs = b_neg ? -lo : lo;
  assign prod = neg_res ? -{hi, lo} : {hi, lo};
  assign add_a = is_div ? {hi, lo[Width-1]} : {1'b0, hi};
  assign add_b = {1'b0, is_div ? mc : (mc & {Width{lo[0]}})};
  assign ready_o = state == IDLE;
  assign valid_o = state == DONE;
  assign result_o = res;
  ibex_multdiv_addsub #(.Width(Width)) u_addsub (
    .a(add_a),
    .b(add_b),
    .sub(is_div),
    .sum(sum),
    .cout(cout)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (valid_i && !kill_i) state_n = (op_i[1] && !DivEn) ? DONE : ABS;
      ABS: state_n = kill_i ? IDLE : (is_div && lo == '0) ? DONE : CALC;
      CALC: state_n = kill_i ? IDLE : (cnt == 5'(MD_CALC_CYCLES - 1)) ? FIX : CALC;
      FIX: state_n = kill_i ? IDLE : DONE;
      DONE: state_n = (kill_i || ready_i) ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q <= MD_OP_MULL;
      sm_q <= '0;
      hi <= '0;
      lo <= '0;
      mc <= '0;
      res <= '0;
      cnt <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      case (state)
        IDLE: if (valid_i && !kill_i) begin
          op_q <= op_i;
          sm_q <= signed_mode_i;
          mc <= op_a_i;
          lo <= op_b_i;
          if (op_i[1] && !DivEn) res <= '0;
        end
        ABS: begin
          hi <= '0;
          cnt <= '0;
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
          mc <= is_div ? b_abs : a_abs;
          lo <= is_div ? a_abs : b_abs;
          if (is_div && lo == '0) res <= (op_q == MD_OP_DIV) ? '1 : mc;
        end
        // Multiply shifts {hi,lo} right; divide shifts the dividend left into the partial remainder.
        CALC: begin
          cnt <= cnt + 5'd1;
          hi <= is_div ? (cout ? sum[Width-1:0] : add_a[Width-1:0]) : sum[Width:1];
          lo <= is_div ? {lo[Width-2:0], cout} : {sum[0], lo[Width-1:1]};
        end
        FIX: res <= is_div ? ((op_q == MD_OP_DIV) ? (neg_res ? -lo : lo) : (neg_rem ? -hi : hi))
                           : ((op_q == MD_OP_MULL) ? prod[Width-1:0] : prod[2*Width-1:Width]);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ibex_multdiv_serial.sv
// tb_ibex_multdiv_serial: randomized and directed checks of ibex_multdiv_serial against an arithmetic model.
module tb_ibex_multdiv_serial;
  import ibex_pkg::*;
`ifdef IBEX_MULTDIV_DIV_EN
  localparam bit div_en = 1'b1;
`else
  localparam bit div_en = 1'b0;
`endif
  logic clk = 1'b0, rst_i = 1'b1, valid_i = 1'b0, kill_i = 1'b0, ready_i = 1'b0;
  logic ready_o, valid_o;
  md_op_e op_i = MD_OP_MULL;
  logic [1:0] signed_mode_i = '0;
  logic [31:0] op_a_i = '0, op_b_i = '0, result_o;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  ibex_multdiv_serial #(.Width(32)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .op_i(op_i),
    .signed_mode_i(signed_mode_i),
    .op_a_i(op_a_i),
    .op_b_i(op_b_i),
    .kill_i(kill_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .result_o(result_o)
  );

  function automatic logic [31:0] model_res(md_op_e op, logic [1:0] sm, logic [31:0] a, logic [31:0] b);
    longint ea, eb;
    logic [63:0] p;
    ea = sm[0] ? longint'($signed(a)) : longint'({32'd0, a});
    eb = sm[1] ? longint'($signed(b)) : longint'({32'd0, b});
    p = 64'(ea * eb);
    case (op)
      MD_OP_MULL: return p[31:0];
      MD_OP_MULH: return p[63:32];
      MD_OP_DIV: return !div_en ? 32'd0 : (b == 0) ? 32'hFFFFFFFF : 32'(ea / eb);
      default: return !div_en ? 32'd0 : (b == 0) ? a : 32'(ea % eb);
    endcase
  endfunction

  function automatic int model_lat(md_op_e op, logic [31:0] b);
    if (op == MD_OP_MULL || op == MD_OP_MULH) return 35;
    if (!div_en) return 1;
    return (b == 0) ? 2 : 35;
  endfunction

  task automatic run_op(input md_op_e op, input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, output logic [31:0] res, output int lat);
    @(negedge clk);
    op_i = op;
    signed_mode_i = sm;
    op_a_i = a;
    op_b_i = b;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (valid_o) break;
      if (noise) begin
        valid_i = 1'b1;
        op_i = md_op_e'($urandom_range(0, 3));
        op_a_i = $urandom;
        op_b_i = $urandom;
      end
    end
    valid_i = 1'b0;
    res = result_o;
    if (valid_o) begin
      ready_i = 1'b1;
      @(posedge clk);
      #1 ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    valid_i = 1'b1;
    kill_i = 1'b1;
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    valid_i = 1'b0;
    kill_i = 1'b0;
    ready_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    n_cmp++;
    if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_cmp++;
    if (result_o !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result_o); end
  endtask

  typedef struct {
    md_op_e op;
    logic [1:0] sm;
    logic [31:0] a, b, exp;
    int lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    logic [31:0] r;
    int l;
    v.push_back('{MD_OP_MULL, 2'b11, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 35});
    v.push_back('{MD_OP_MULH, 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 35});
    v.push_back('{MD_OP_MULH, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35});
    v.push_back('{MD_OP_MULH, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35});
    v.push_back('{MD_OP_DIV, 2'b11, 32'hFFFFFFF9, 32'd2, div_en ? 32'hFFFFFFFD : 32'd0, div_en ? 35 : 1});
    v.push_back('{MD_OP_REM, 2'b11, 32'hFFFFFFF9, 32'd2, div_en ? 32'hFFFFFFFF : 32'd0, div_en ? 35 : 1});
    v.push_back('{MD_OP_DIV, 2'b00, 32'd5, 32'd0, div_en ? 32'hFFFFFFFF : 32'd0, div_en ? 2 : 1});
    v.push_back('{MD_OP_REM, 2'b00, 32'd5, 32'd0, div_en ? 32'd5 : 32'd0, div_en ? 2 : 1});
    v.push_back('{MD_OP_DIV, 2'b11, 32'h80000000, 32'hFFFFFFFF, div_en ? 32'h80000000 : 32'd0, div_en ? 35 : 1});
    v.push_back('{MD_OP_REM, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, div_en ? 35 : 1});
    v.push_back('{MD_OP_DIV, 2'b00, 32'd100, 32'd7, div_en ? 32'd14 : 32'd0, div_en ? 35 : 1});
    v.push_back('{MD_OP_REM, 2'b00, 32'd100, 32'd7, div_en ? 32'd2 : 32'd0, div_en ? 35 : 1});
    foreach (v[i]) begin
      run_op(v[i].op, v[i].sm, v[i].a, v[i].b, 1'b0, r, l);
      n_cmp++;
      if (r !== v[i].exp) begin
        n_bad++;
        $display("FAIL directed_%0d_result: got %h want %h", i, r, v[i].exp);
      end
      n_cmp++;
      if (l !== v[i].lat) begin
        n_bad++;
        $display("FAIL directed_%0d_latency: got %0d want %0d", i, l, v[i].lat);
      end
    end
  endtask

  task automatic test_random();
    md_op_e op;
    logic [1:0] sm;
    logic [31:0] a, b, r;
    int l;
    for (int i = 0; i < 24; i++) begin
      op = md_op_e'($urandom_range(0, 3));
      sm = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(op, sm, a, b, i[0], r, l);
      n_cmp++;
      if (r !== model_res(op, sm, a, b)) begin
        n_bad++;
        $display("FAIL random_%0d_result: op %0d sm %b a %h b %h got %h want %h", i, op, sm, a, b, r,
                 model_res(op, sm, a, b));
      end
      n_cmp++;
      if (l !== model_lat(op, b)) begin
        n_bad++;
        $display("FAIL random_%0d_latency: got %0d want %0d", i, l, model_lat(op, b));
      end
    end
  endtask

  task automatic test_kill();
    int seen = 0;
    logic [31:0] r;
    int l;
    @(negedge clk);
    op_i = MD_OP_MULL;
    signed_mode_i = 2'b00;
    op_a_i = 32'd1234;
    op_b_i = 32'd5678;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    kill_i = 1'b1;
    @(posedge clk);
    #1 kill_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL kill_ready: got %b want 1", ready_o); end
    for (int c = 0; c < 40; c++) begin
      if (valid_o) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL kill_no_valid: got %0d valid cycles want 0", seen); end
    run_op(MD_OP_MULL, 2'b00, 32'd3, 32'd4, 1'b0, r, l);
    n_cmp++;
    if (r !== 32'd12) begin n_bad++; $display("FAIL kill_next_result: got %h want 0000000c", r); end
    n_cmp++;
    if (l !== 35) begin n_bad++; $display("FAIL kill_next_latency: got %0d want 35", l); end
  endtask

  task automatic test_kill_idle();
    int seen = 0;
    @(negedge clk);
    op_i = MD_OP_MULL;
    op_a_i = 32'd9;
    op_b_i = 32'd9;
    valid_i = 1'b1;
    kill_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    kill_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1) begin n_bad++; $display("FAIL kill_idle_ready: got %b want 1", ready_o); end
    for (int c = 0; c < 40; c++) begin
      if (valid_o) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL kill_idle_no_valid: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_hold();
    int l = 0;
    logic [31:0] r0;
    @(negedge clk);
    op_i = MD_OP_MULH;
    signed_mode_i = 2'b11;
    op_a_i = 32'h80000000;
    op_b_i = 32'h80000000;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    while (l < 100) begin
      @(negedge clk);
      l++;
      if (valid_o) break;
    end
    r0 = result_o;
    n_cmp++;
    if (r0 !== 32'h40000000) begin n_bad++; $display("FAIL hold_result: got %h want 40000000", r0); end
    n_cmp++;
    if (l !== 35) begin n_bad++; $display("FAIL hold_latency: got %0d want 35", l); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (valid_o !== 1'b1 || result_o !== r0) begin
        n_bad++;
        $display("FAIL hold_stable_%0d: got valid %b result %h want 1 %h", c, valid_o, result_o, r0);
      end
    end
    ready_i = 1'b1;
    @(posedge clk);
    #1 ready_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_release: got valid %b ready %b want 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    op_i = MD_OP_MULL;
    signed_mode_i = 2'b11;
    op_a_i = $urandom;
    op_b_i = $urandom;
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    rst_i = 1'b1;
    kill_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    kill_i = 1'b0;
    ready_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_mid_state: got valid %b ready %b result %h want 0 1 0", valid_o, ready_o, result_o);
    end
    for (int c = 0; c < 40; c++) begin
      if (valid_o) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL reset_mid_no_valid: got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_kill();
    test_kill_idle();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
